int_ctrl_multi: RTL and testbench

- Parametrised multi-source interrupt controller; successor to the single-INT scheme of the multi-cycle CPU.
- Collects NUM_SRC interrupt lines, synchronises them and applies per-channel mask and edge/level mode.
- Arbitrates by fixed priority (lowest index wins) and presents one request, channel id and handler vector to the CPU through a req/ack/done handshake.
- Sits between peripherals and the CPU core; configured through a small register port on the CPU data bus.

---
 rtl/int_ctrl_multi.sv | 115 +++++++++++
 tb/tb_int_ctrl_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_multi.sv
// Multi-source interrupt controller: synchronises NUM_SRC lines and applies per-channel mask and edge/level mode.
// The lowest-index eligible channel is presented to the CPU over a req/ack/done handshake.
module int_ctrl_multi #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 32'h0000_0010,
  localparam int unsigned ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              int_req,
  input  logic              int_ack,
  input  logic              int_done,
  output logic [ID_W-1:0]   int_id,
  output logic [ADDR_W-1:0] int_vector
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t state, state_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, s_d, mask, mode, pend, pend_nxt;
  logic [NUM_SRC-1:0] rise, clr, eligible;
  logic [ID_W-1:0]    winner;
  logic               unused_wdata;

  assign s = sync_q[SYNC_STAGES-1];
  assign unused_wdata = ^reg_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d  <= '0;
      mask <= '0;
      mode <= '0;
      pend <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d  <= s;
      pend <= pend_nxt;
      if (reg_we && reg_addr == 2'd0) mask <= reg_wdata[NUM_SRC-1:0];
      if (reg_we && reg_addr == 2'd1) mode <= reg_wdata[NUM_SRC-1:0];
    end
  end

  // Edge bits: a new rising edge overrides any clear in the same cycle so no edge is lost.
  always_comb begin
    rise = s & ~s_d;
    clr  = '0;
    if (reg_we && reg_addr == 2'd2) clr = reg_wdata[NUM_SRC-1:0];
    if (state == REQ && int_ack) clr[int_id] = 1'b1;
    pend_nxt = (mode & (rise | (pend & ~clr))) | (~mode & s);
  end

  always_comb begin
    eligible = pend & mask;
    winner   = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (eligible[i-1]) winner = ID_W'(i - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      int_id <= '0;
    end else begin
      state  <= state_nxt;
      int_id <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = int_id;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = REQ;
          id_nxt    = winner;
        end
      end
      REQ:     if (int_ack)  state_nxt = SERVICE;
      SERVICE: if (int_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign int_req    = (state == REQ);
  assign int_vector = VEC_BASE + ADDR_W'(int_id) * VEC_STRIDE;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      2'd0: reg_rdata = DATA_W'(mask);
      2'd1: reg_rdata = DATA_W'(mode);
      2'd2: reg_rdata = DATA_W'(pend);
      default: begin
        reg_rdata[ID_W-1:0] = int_id;
        reg_rdata[DATA_W-1] = (state == SERVICE);
      end
    endcase
  end

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Bench for int_ctrl_multi: directed scenarios plus random traffic, all checked against an in-bench model.
module tb_int_ctrl_multi;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        int_req;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;
  logic [2:0]  int_id;
  logic [31:0] int_vector;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  logic [31:0] rv;

  int_ctrl_multi #(.NUM_SRC(8), .DATA_W(32), .ADDR_W(32), .SYNC_STAGES(S),
                   .VEC_BASE(32'h100), .VEC_STRIDE(32'h10)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .int_req(int_req), .int_ack(int_ack),
    .int_done(int_done), .int_id(int_id), .int_vector(int_vector));

  always #5 clk = ~clk;

  // Model: m_hist[k] is the irq_in value seen k+1 edges ago; phase 0 idle, 1 requesting, 2 in service.
  logic [7:0] m_hist [0:S];
  logic [7:0] m_mask = '0, m_mode = '0, m_pend = '0;
  int         m_phase = 0;
  int         m_id = 0;
  logic [7:0] t_s, t_rise, t_clr, t_newp, t_elig;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) lowest = i;
  endfunction

  always_comb begin
    t_s    = m_hist[S-1];
    t_rise = m_hist[S-1] & ~m_hist[S];
    t_clr  = (reg_we && reg_addr == 2'd2) ? reg_wdata[7:0] : 8'h00;
    if (m_phase == 1 && int_ack) t_clr = t_clr | (8'h01 << m_id);
    for (int i = 0; i < 8; i++)
      t_newp[i] = m_mode[i] ? (t_rise[i] || (m_pend[i] && !t_clr[i])) : t_s[i];
    t_elig = m_pend & m_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= S; k++) m_hist[k] <= '0;
      m_mask <= '0; m_mode <= '0; m_pend <= '0; m_phase <= 0; m_id <= 0;
    end else begin
      m_pend <= t_newp;
      if (reg_we && reg_addr == 2'd0) m_mask <= reg_wdata[7:0];
      if (reg_we && reg_addr == 2'd1) m_mode <= reg_wdata[7:0];
      if (m_phase == 0 && t_elig != 0) begin
        m_phase <= 1; m_id <= lowest(t_elig);
      end else if (m_phase == 1 && int_ack) m_phase <= 2;
      else if (m_phase == 2 && int_done) m_phase <= 0;
      m_hist[0] <= irq_in;
      for (int k = 1; k <= S; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0: exp_rd = {24'h0, m_mask};
      2'd1: exp_rd = {24'h0, m_mode};
      2'd2: exp_rd = {24'h0, m_pend};
      default: exp_rd = ((m_phase == 2) ? 32'h8000_0000 : 32'h0) | 32'(m_id);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req", 32'(int_req), (m_phase == 1) ? 32'd1 : 32'd0);
      chk("m_id", 32'(int_id), 32'(m_id));
      chk("m_vec", int_vector, 32'h100 + 32'(m_id) * 32'h10);
      chk("m_rdata", reg_rdata, exp_rd(reg_addr));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cyc();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a; #1; d = reg_rdata;
  endtask

  task automatic pulse(input int ch);
    irq_in[ch] = 1'b1; cyc(); irq_in[ch] = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!int_req && n < 12) begin cyc(); n++; end
    chk("wait_req", 32'(int_req), 32'd1);
  endtask

  task automatic ack();
    int_ack = 1'b1; cyc(); int_ack = 1'b0;
  endtask

  task automatic done();
    int_done = 1'b1; cyc(); int_done = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_req", 32'(int_req), 0);
    chk("rst_vec", int_vector, 32'h100);
    rd(2'd3, rv); chk("rst_status", rv, 0);

    // single edge pulse on ch5, latency to request
    wr(2'd0, 32'hFF); wr(2'd1, 32'hFF);
    irq_in[5] = 1'b1; cyc(); irq_in[5] = 1'b0;
    cyc(); cyc();
    chk("lat_req_lo", 32'(int_req), 0);
    rd(2'd2, rv); chk("lat_pend", rv, 32'h20);
    cyc();
    chk("lat_req_hi", 32'(int_req), 1);
    chk("lat_id", 32'(int_id), 5);
    chk("lat_vec", int_vector, 32'h150);
    ack();
    chk("ack_req", 32'(int_req), 0);
    rd(2'd2, rv); chk("ack_pend", rv, 0);
    rd(2'd3, rv); chk("svc_status", rv, 32'h8000_0005);
    done();
    rd(2'd3, rv); chk("done_insvc", 32'(rv[31]), 0);

    // simultaneous ch6 and ch2: priority, then idle gap
    irq_in[6] = 1'b1; irq_in[2] = 1'b1; cyc(); irq_in = '0;
    wait_req();
    chk("prio_id", 32'(int_id), 2);
    ack(); done();
    chk("gap_req", 32'(int_req), 0);
    cyc();
    chk("second_req", 32'(int_req), 1);
    chk("second_id", 32'(int_id), 6);
    chk("second_vec", int_vector, 32'h160);
    ack(); done(); cyc();

    // masked channel pends until unmasked
    wr(2'd0, 32'h00);
    pulse(3); cyc(); cyc(); cyc();
    rd(2'd2, rv); chk("mask_pend", rv, 32'h08);
    chk("mask_noreq", 32'(int_req), 0);
    wr(2'd0, 32'h08);
    chk("unmask_req0", 32'(int_req), 0);
    cyc();
    chk("unmask_req1", 32'(int_req), 1);
    chk("unmask_id", 32'(int_id), 3);
    ack(); done(); cyc();

    // new edge on ch1 coincident with W1C, then coincident with ack
    wr(2'd0, 32'h00);
    pulse(1); cyc(); cyc(); cyc();
    pulse(1); cyc();
    wr(2'd2, 32'h02);
    rd(2'd2, rv); chk("w1c_race_pend", rv, 32'h02);
    wr(2'd0, 32'hFF);
    wait_req();
    chk("w1c_race_id", 32'(int_id), 1);
    pulse(1); cyc();
    ack();
    rd(2'd2, rv); chk("ack_race_pend", rv, 32'h02);
    done();
    chk("ack_race_gap", 32'(int_req), 0);
    cyc();
    chk("ack_race_rereq", 32'(int_req), 1);
    chk("ack_race_id", 32'(int_id), 1);
    ack(); done(); cyc();

    // level ch0 held through done, then dropped before done
    wr(2'd1, 32'hFE);
    irq_in[0] = 1'b1;
    wait_req();
    chk("lvl_id", 32'(int_id), 0);
    ack(); done();
    chk("lvl_gap", 32'(int_req), 0);
    cyc();
    chk("lvl_rereq", 32'(int_req), 1);
    ack();
    irq_in[0] = 1'b0;
    repeat (4) cyc();
    done();
    repeat (4) begin cyc(); chk("lvl_drop_noreq", 32'(int_req), 0); end

    // async reset while in service with edges pending
    wr(2'd1, 32'hFF);
    pulse(4);
    wait_req();
    ack();
    irq_in[2] = 1'b1; irq_in[6] = 1'b1; cyc(); irq_in = '0;
    cyc(); cyc(); cyc();
    rd(2'd2, rv); chk("pre_rst_pend", rv, 32'h44);
    rd(2'd3, rv); chk("pre_rst_status", rv, 32'h8000_0004);
    #1 reset = 1'b1;
    #1 chk("arst_req", 32'(int_req), 0);
    rd(2'd2, rv); chk("arst_pend", rv, 0);
    rd(2'd3, rv); chk("arst_status", rv, 0);
    cyc(); cyc();
    reset = 1'b0;
    repeat (6) begin cyc(); chk("post_rst_noreq", 32'(int_req), 0); end

    // random traffic against the model
    wr(2'd0, 32'hFF);
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      reg_we    = ($urandom_range(0, 9) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = $urandom;
      int_ack   = ($urandom_range(0, 2) == 0);
      int_done  = ($urandom_range(0, 3) == 0);
      cyc();
    end
    reg_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
